// File: rtl/pipe_pkg.sv
// ============================================================================
// pipe_pkg : shared state encoding, colours and LFSR definition for pipe_field
// Rev 1.0
// ============================================================================
`default_nettype none

package pipe_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_HIT  = 2'd2
    } state_t;

    // Colours packed as {R, G, B}
    localparam logic [2:0] RGB_BLACK = 3'b000;
    localparam logic [2:0] RGB_PIPE  = 3'b010;
    localparam logic [2:0] RGB_HIT   = 3'b110;

    localparam logic [7:0] LFSR_SEED = 8'hA5;
    // Taps 8,6,5,4 expressed as a mask over bits [7:0]
    localparam logic [7:0] LFSR_TAPS = 8'b1011_1000;

    function automatic logic [7:0] lfsr_step(input logic [7:0] v);
        return {v[6:0], ^(v & LFSR_TAPS)};
    endfunction

endpackage

`default_nettype wire

// File: rtl/pipe_field_lane.sv
// ============================================================================
// pipe_lane : one pipe's position, gap, wrap, pixel coverage and score crossing
// Rev 1.0
// ============================================================================
`default_nettype none

module pipe_lane
    import pipe_pkg::*;
#(
    parameter int INDEX     = 0,
    parameter int NUM_PIPES = 2,
    parameter int SCREEN_W  = 640,
    parameter int PIPE_W    = 40,
    parameter int GAP_H     = 120,
    parameter int GAP_MIN   = 40,
    parameter int SPACING   = 360,
    parameter int SPEED     = 2,
    parameter int BIRD_X    = 160
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [9:0] counter_x,
    input  logic [8:0] counter_y,
    input  logic       move,
    input  logic       reload,
    input  logic [6:0] rnd,
    output logic       covers,
    output logic       crossed
);

    localparam logic [10:0] X_INIT   = 11'(SCREEN_W + PIPE_W + INDEX * SPACING);
    localparam logic [8:0]  G_INIT   = 9'(GAP_MIN + 64);
    localparam logic [8:0]  G_MIN    = 9'(GAP_MIN);
    localparam logic [10:0] WIDTH    = 11'(PIPE_W);
    localparam logic [10:0] STEP     = 11'(SPEED);
    localparam logic [10:0] WRAP_ADD = 11'(NUM_PIPES * SPACING - SPEED);
    localparam logic [10:0] BIRD_COL = 11'(BIRD_X);
    localparam logic [9:0]  GAP_HGT  = 10'(GAP_H);

    logic [10:0] x;
    logic [10:0] x_next;
    logic [8:0]  g;
    logic        wrap;
    logic [10:0] cx;
    logic [9:0]  cy;
    logic        in_cols;
    logic        in_rows;

    always_comb begin
        wrap   = (x < STEP);
        x_next = wrap ? (x + WRAP_ADD) : (x - STEP);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x <= X_INIT;
            g <= G_INIT;
        end else if (reload) begin
            x <= X_INIT;
            g <= G_INIT;
        end else if (move) begin
            x <= x_next;
            if (wrap) begin
                g <= G_MIN + {2'b00, rnd};
            end
        end
    end

    // Left edge tested as cx + WIDTH >= x so nothing underflows near column 0
    always_comb begin
        cx      = {1'b0, counter_x};
        cy      = {1'b0, counter_y};
        in_cols = (cx < x) && ((cx + WIDTH) >= x);
        in_rows = (cy < {1'b0, g}) || (cy >= ({1'b0, g} + GAP_HGT));
        covers  = in_cols && in_rows;
        crossed = move && (x > BIRD_COL) && (x_next <= BIRD_COL);
    end

endmodule

`default_nettype wire

// File: rtl/pipe_field.sv
// ============================================================================
// pipe_field : scrolling pipe obstacles with colour output, collision and score
// Rev 1.0
// ============================================================================
`default_nettype none

module pipe_field
    import pipe_pkg::*;
#(
    parameter int NUM_PIPES = 2,
    parameter int SCREEN_W  = 640,
    parameter int SCREEN_H  = 480,
    parameter int PIPE_W    = 40,
    parameter int GAP_H     = 120,
    parameter int GAP_MIN   = 40,
    parameter int SPACING   = 360,
    parameter int SPEED     = 2,
    parameter int BIRD_X    = 160
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic [9:0] CounterX,
    input  logic [8:0] CounterY,
    input  logic       FrameTick,
    input  logic       Start,
    input  logic       BirdPixel,
    output logic       R,
    output logic       G,
    output logic       B,
    output logic       Collision,
    output logic [7:0] Score,
    output logic [1:0] State
);

    if (GAP_MIN + 127 + GAP_H > SCREEN_H) begin : g_chk_gap
        $error("pipe_field: GAP_MIN+127+GAP_H exceeds SCREEN_H");
    end
    if (SCREEN_W + PIPE_W + (NUM_PIPES - 1) * SPACING >= 2048) begin : g_chk_xmax
        $error("pipe_field: initial x of last pipe does not fit 11 bits");
    end
    if (NUM_PIPES * SPACING < SCREEN_W + PIPE_W) begin : g_chk_spacing
        $error("pipe_field: NUM_PIPES*SPACING smaller than SCREEN_W+PIPE_W");
    end

    state_t                 state;
    state_t                 state_next;
    logic [7:0]             lfsr;
    logic [7:0]             lfsr_next;
    logic [7:0]             score;
    logic [2:0]             rgb;
    logic [NUM_PIPES-1:0]   covers;
    logic [NUM_PIPES-1:0]   crossed;
    logic                   in_screen;
    logic                   pipe_pix;
    logic                   hit_now;
    logic                   move;
    logic                   reload;
    logic [3:0]             cross_cnt;
    logic [8:0]             score_sum;

    for (genvar i = 0; i < NUM_PIPES; i++) begin : g_lanes
        pipe_lane #(
            .INDEX     (i),
            .NUM_PIPES (NUM_PIPES),
            .SCREEN_W  (SCREEN_W),
            .PIPE_W    (PIPE_W),
            .GAP_H     (GAP_H),
            .GAP_MIN   (GAP_MIN),
            .SPACING   (SPACING),
            .SPEED     (SPEED),
            .BIRD_X    (BIRD_X)
        ) u_lane (
            .clk       (Clk),
            .rst_n     (Reset),
            .counter_x (CounterX),
            .counter_y (CounterY),
            .move      (move),
            .reload    (reload),
            .rnd       (lfsr_next[6:0]),
            .covers    (covers[i]),
            .crossed   (crossed[i])
        );
    end

    always_comb begin
        in_screen = ({1'b0, CounterX} < 11'(SCREEN_W)) && ({1'b0, CounterY} < 10'(SCREEN_H));
        pipe_pix  = in_screen && (|covers);
        hit_now   = (state == ST_RUN) && BirdPixel && pipe_pix;
        // A collision on the tick cycle wins: nothing moves or scores
        move      = (state == ST_RUN) && FrameTick && !hit_now;
        lfsr_next = lfsr_step(lfsr);
    end

    always_comb begin
        state_next = state;
        reload     = 1'b0;
        case (state)
            ST_IDLE: if (Start)   state_next = ST_RUN;
            ST_RUN:  if (hit_now) state_next = ST_HIT;
            ST_HIT: begin
                if (Start) begin
                    state_next = ST_IDLE;
                    reload     = 1'b1;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        cross_cnt = '0;
        for (int i = 0; i < NUM_PIPES; i++) begin
            cross_cnt = cross_cnt + {3'b000, crossed[i]};
        end
        score_sum = {1'b0, score} + {5'b00000, cross_cnt};
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state <= ST_IDLE;
            lfsr  <= LFSR_SEED;
            score <= '0;
            rgb   <= RGB_BLACK;
        end else begin
            state <= state_next;
            if (move) begin
                lfsr <= lfsr_next;
            end
            if (reload) begin
                score <= '0;
            end else if (move) begin
                score <= score_sum[8] ? 8'hFF : score_sum[7:0];
            end
            if (pipe_pix) begin
                rgb <= (state == ST_HIT) ? RGB_HIT : RGB_PIPE;
            end else begin
                rgb <= RGB_BLACK;
            end
        end
    end

    assign {R, G, B}  = rgb;
    assign Collision  = (state == ST_HIT);
    assign Score      = score;
    assign State      = state;

endmodule

`default_nettype wire

// File: tb/tb_pipe_field.sv
// ============================================================================
// tb_pipe_field : scoreboard-based bench for pipe_field
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_pipe_field;

    logic       Clk = 1'b0;
    logic       Reset = 1'b0;
    logic [9:0] CounterX = 10'd1000;
    logic [8:0] CounterY = 9'd500;
    logic       FrameTick = 1'b0;
    logic       Start = 1'b0;
    logic       BirdPixel = 1'b0;
    logic       R, G, B, Collision;
    logic [7:0] Score;
    logic [1:0] State;

    // Second instance with a tiny playfield so saturation is reachable quickly
    logic       tick2 = 1'b0;
    logic       start2 = 1'b0;
    logic       r2, g2, b2, col2;
    logic [7:0] score2;
    logic [1:0] state2;

    int tests = 0;
    int fails = 0;

    logic [2:0]  exp_q[$];
    logic [10:0] mx[2];
    logic [8:0]  mg[2];
    logic [7:0]  mlfsr;
    int          mscore;
    int          mstate;

    pipe_field dut (
        .Clk(Clk), .Reset(Reset), .CounterX(CounterX), .CounterY(CounterY),
        .FrameTick(FrameTick), .Start(Start), .BirdPixel(BirdPixel),
        .R(R), .G(G), .B(B), .Collision(Collision), .Score(Score), .State(State)
    );

    pipe_field #(
        .NUM_PIPES(2), .SCREEN_W(64), .SCREEN_H(480), .PIPE_W(8), .GAP_H(120),
        .GAP_MIN(40), .SPACING(36), .SPEED(8), .BIRD_X(16)
    ) dut2 (
        .Clk(Clk), .Reset(Reset), .CounterX(CounterX), .CounterY(CounterY),
        .FrameTick(tick2), .Start(start2), .BirdPixel(1'b0),
        .R(r2), .G(g2), .B(b2), .Collision(col2), .Score(score2), .State(state2)
    );

    always #5 Clk = ~Clk;

    function automatic logic [7:0] model_lfsr(input logic [7:0] v);
        return {v[6:0], v[7] ^ v[5] ^ v[4] ^ v[3]};
    endfunction

    function automatic logic [2:0] model_rgb(input int x, input int y);
        bit cov = 1'b0;
        if (x >= 640 || y >= 480) return 3'b000;
        for (int i = 0; i < 2; i++) begin
            if (x < int'(mx[i]) && x + 40 >= int'(mx[i]) &&
                (y < int'(mg[i]) || y >= int'(mg[i]) + 120)) cov = 1'b1;
        end
        if (!cov) return 3'b000;
        return (mstate == 2) ? 3'b110 : 3'b010;
    endfunction

    task automatic model_reset();
        mx[0] = 11'd680; mx[1] = 11'd1040;
        mg[0] = 9'd104;  mg[1] = 9'd104;
        mlfsr = 8'hA5; mscore = 0; mstate = 0;
    endtask

    task automatic model_tick();
        logic [7:0]  nl;
        logic [10:0] nx;
        if (mstate != 1) return;
        nl = model_lfsr(mlfsr);
        for (int i = 0; i < 2; i++) begin
            if (mx[i] < 11'd2) begin
                nx = mx[i] + 11'd718;
                mg[i] = 9'd40 + {2'b00, nl[6:0]};
            end else begin
                nx = mx[i] - 11'd2;
            end
            if (mx[i] > 11'd160 && nx <= 11'd160) mscore = (mscore < 255) ? mscore + 1 : 255;
            mx[i] = nx;
        end
        mlfsr = nl;
    endtask

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic tick();
        FrameTick = 1'b1;
        model_tick();
        step();
        FrameTick = 1'b0;
    endtask

    // Drive one pixel, queue its expected colour, compare when it emerges
    task automatic pixel(input int x, input int y, input bit bird);
        logic [2:0] exp_rgb;
        logic [2:0] got;
        CounterX  = 10'(x);
        CounterY  = 9'(y);
        BirdPixel = bird;
        exp_q.push_back(model_rgb(x, y));
        if (bird && mstate == 1 && model_rgb(x, y) != 3'b000) mstate = 2;
        step();
        BirdPixel = 1'b0;
        got = {R, G, B};
        exp_rgb = exp_q.pop_front();
        tests++;
        if (got !== exp_rgb) begin
            fails++;
            $display("FAIL rgb(%0d,%0d) got=%b exp=%b", x, y, got, exp_rgb);
        end
    endtask

    task automatic test_reset();
        Reset = 1'b0;
        repeat (3) step();
        model_reset();
        tests++; if (State !== 2'd0 || Collision !== 1'b0) begin fails++; $display("FAIL reset_state got=%0d/%b exp=0/0", State, Collision); end
        tests++; if (Score !== 8'd0 || {R, G, B} !== 3'b000) begin fails++; $display("FAIL reset_outs got=%0d/%b exp=0/000", Score, {R, G, B}); end
        tests++; if (dut.g_lanes[0].u_lane.x !== 11'd680 || dut.g_lanes[1].u_lane.x !== 11'd1040) begin fails++; $display("FAIL reset_x got=%0d/%0d exp=680/1040", dut.g_lanes[0].u_lane.x, dut.g_lanes[1].u_lane.x); end
        tests++; if (dut.g_lanes[0].u_lane.g !== 9'd104 || dut.lfsr !== 8'hA5) begin fails++; $display("FAIL reset_g_lfsr got=%0d/%h exp=104/a5", dut.g_lanes[0].u_lane.g, dut.lfsr); end
        @(negedge Clk);
        Reset = 1'b1;
        step();
    endtask

    task automatic test_idle_frozen();
        repeat (10) tick();
        pixel(10, 10, 1'b0);
        pixel(660, 10, 1'b0);
        tests++; if (dut.g_lanes[0].u_lane.x !== 11'd680 || dut.g_lanes[1].u_lane.x !== 11'd1040) begin fails++; $display("FAIL idle_x got=%0d/%0d exp=680/1040", dut.g_lanes[0].u_lane.x, dut.g_lanes[1].u_lane.x); end
        tests++; if (Score !== 8'd0 || State !== 2'd0) begin fails++; $display("FAIL idle_score_state got=%0d/%0d exp=0/0", Score, State); end
        // Start on a tick cycle: enters RUN without moving
        Start = 1'b1; FrameTick = 1'b1;
        step();
        Start = 1'b0; FrameTick = 1'b0;
        mstate = 1;
        tests++; if (State !== 2'd1 || dut.g_lanes[0].u_lane.x !== 11'd680 || dut.lfsr !== 8'hA5) begin fails++; $display("FAIL start_tick got=%0d/%0d/%h exp=1/680/a5", State, dut.g_lanes[0].u_lane.x, dut.lfsr); end
    endtask

    task automatic test_run_score();
        for (int k = 1; k <= 270; k++) begin
            tick();
            if (k == 259) begin
                tests++; if (Score !== 8'd0) begin fails++; $display("FAIL score_t259 got=%0d exp=0", Score); end
            end
            if (k == 260) begin
                tests++; if (Score !== 8'd1 || dut.g_lanes[0].u_lane.x !== 11'd160) begin fails++; $display("FAIL score_t260 got=%0d/%0d exp=1/160", Score, dut.g_lanes[0].u_lane.x); end
            end
        end
        tests++; if (dut.g_lanes[0].u_lane.x !== 11'd140 || dut.g_lanes[1].u_lane.x !== 11'd500) begin fails++; $display("FAIL run_x got=%0d/%0d exp=140/500", dut.g_lanes[0].u_lane.x, dut.g_lanes[1].u_lane.x); end
        tests++; if (int'(Score) != mscore || dut.lfsr !== mlfsr) begin fails++; $display("FAIL run_score_lfsr got=%0d/%h exp=%0d/%h", Score, dut.lfsr, mscore, mlfsr); end
        pixel(100, 10, 1'b0);  pixel(99, 10, 1'b0);
        pixel(139, 10, 1'b0);  pixel(140, 10, 1'b0);
        pixel(120, 103, 1'b0); pixel(120, 104, 1'b0);
        pixel(120, 223, 1'b0); pixel(120, 224, 1'b0);
        pixel(460, 300, 1'b0); pixel(499, 479, 1'b0);
        pixel(499, 480, 1'b1);
        tests++; if (State !== 2'd1) begin fails++; $display("FAIL offscreen_bird got=%0d exp=1", State); end
    endtask

    task automatic test_wrap();
        for (int k = 271; k <= 341; k++) tick();
        tests++; if (dut.g_lanes[0].u_lane.x !== 11'd718 || dut.g_lanes[1].u_lane.x !== 11'd358) begin fails++; $display("FAIL wrap_x got=%0d/%0d exp=718/358", dut.g_lanes[0].u_lane.x, dut.g_lanes[1].u_lane.x); end
        tests++; if (dut.g_lanes[0].u_lane.g !== mg[0] || dut.lfsr !== mlfsr) begin fails++; $display("FAIL wrap_gap got=%0d/%h exp=%0d/%h", dut.g_lanes[0].u_lane.g, dut.lfsr, mg[0], mlfsr); end
        tests++; if (dut.g_lanes[1].u_lane.g !== 9'd104) begin fails++; $display("FAIL wrap_g1 got=%0d exp=104", dut.g_lanes[1].u_lane.g); end
        pixel(318, 10, 1'b0);  pixel(317, 10, 1'b0);
        pixel(357, 103, 1'b0); pixel(357, 104, 1'b0);
        pixel(639, 10, 1'b0);
    endtask

    task automatic test_collision();
        logic [2:0] got;
        logic [2:0] exp_rgb;
        CounterX = 10'd330; CounterY = 9'd10;
        BirdPixel = 1'b1; FrameTick = 1'b1;
        exp_q.push_back(model_rgb(330, 10));
        step();
        BirdPixel = 1'b0; FrameTick = 1'b0;
        mstate = 2;
        got = {R, G, B}; exp_rgb = exp_q.pop_front();
        tests++; if (got !== exp_rgb) begin fails++; $display("FAIL hit_cycle_rgb got=%b exp=%b", got, exp_rgb); end
        tests++; if (State !== 2'd2 || Collision !== 1'b1) begin fails++; $display("FAIL hit_state got=%0d/%b exp=2/1", State, Collision); end
        tests++; if (dut.g_lanes[1].u_lane.x !== 11'd358 || dut.g_lanes[0].u_lane.x !== 11'd718 || int'(Score) != mscore) begin fails++; $display("FAIL hit_no_move got=%0d/%0d/%0d exp=358/718/%0d", dut.g_lanes[1].u_lane.x, dut.g_lanes[0].u_lane.x, Score, mscore); end
        pixel(330, 10, 1'b0);
        pixel(330, 150, 1'b0);
        repeat (5) tick();
        tests++; if (dut.g_lanes[1].u_lane.x !== 11'd358 || dut.lfsr !== mlfsr || State !== 2'd2) begin fails++; $display("FAIL hit_frozen got=%0d/%h/%0d exp=358/%h/2", dut.g_lanes[1].u_lane.x, dut.lfsr, State, mlfsr); end
    endtask

    task automatic test_restart();
        Start = 1'b1;
        step();
        Start = 1'b0;
        mx[0] = 11'd680; mx[1] = 11'd1040; mg[0] = 9'd104; mg[1] = 9'd104;
        mscore = 0; mstate = 0;
        tests++; if (State !== 2'd0 || Collision !== 1'b0 || Score !== 8'd0) begin fails++; $display("FAIL restart_state got=%0d/%b/%0d exp=0/0/0", State, Collision, Score); end
        tests++; if (dut.g_lanes[0].u_lane.x !== 11'd680 || dut.g_lanes[1].u_lane.x !== 11'd1040 || dut.g_lanes[0].u_lane.g !== 9'd104) begin fails++; $display("FAIL restart_pos got=%0d/%0d/%0d exp=680/1040/104", dut.g_lanes[0].u_lane.x, dut.g_lanes[1].u_lane.x, dut.g_lanes[0].u_lane.g); end
        tests++; if (dut.lfsr !== mlfsr) begin fails++; $display("FAIL restart_lfsr got=%h exp=%h", dut.lfsr, mlfsr); end
    endtask

    task automatic test_saturation();
        logic [10:0] sx[2];
        logic [10:0] nx;
        int ss = 0;
        sx[0] = 11'd72; sx[1] = 11'd108;
        start2 = 1'b1;
        step();
        start2 = 1'b0;
        for (int k = 1; k <= 1300; k++) begin
            tick2 = 1'b1;
            for (int i = 0; i < 2; i++) begin
                nx = (sx[i] < 11'd8) ? sx[i] + 11'd64 : sx[i] - 11'd8;
                if (sx[i] > 11'd16 && nx <= 11'd16) ss = (ss < 255) ? ss + 1 : 255;
                sx[i] = nx;
            end
            step();
            tick2 = 1'b0;
            if (k == 20) begin
                tests++; if (int'(score2) != ss) begin fails++; $display("FAIL sat_mid got=%0d exp=%0d", score2, ss); end
            end
        end
        tests++; if (score2 !== 8'd255 || ss != 255) begin fails++; $display("FAIL sat_final got=%0d exp=255 (model %0d)", score2, ss); end
        tests++; if (state2 !== 2'd1) begin fails++; $display("FAIL sat_state got=%0d exp=1", state2); end
    endtask

    task automatic test_reset_mid_run();
        Start = 1'b1;
        step();
        Start = 1'b0;
        mstate = 1;
        for (int k = 0; k < 270; k++) tick();
        tests++; if (int'(Score) != mscore || dut.g_lanes[0].u_lane.x !== mx[0]) begin fails++; $display("FAIL rerun got=%0d/%0d exp=%0d/%0d", Score, dut.g_lanes[0].u_lane.x, mscore, mx[0]); end
        pixel(120, 10, 1'b0);
        #2;
        Reset = 1'b0;
        #1;
        tests++; if (State !== 2'd0 || Collision !== 1'b0 || Score !== 8'd0 || {R, G, B} !== 3'b000) begin fails++; $display("FAIL async_reset_outs got=%0d/%b/%0d/%b exp=0/0/0/000", State, Collision, Score, {R, G, B}); end
        tests++; if (dut.g_lanes[0].u_lane.x !== 11'd680 || dut.g_lanes[1].u_lane.x !== 11'd1040 || dut.g_lanes[0].u_lane.g !== 9'd104 || dut.lfsr !== 8'hA5) begin fails++; $display("FAIL async_reset_regs got=%0d/%0d/%0d/%h exp=680/1040/104/a5", dut.g_lanes[0].u_lane.x, dut.g_lanes[1].u_lane.x, dut.g_lanes[0].u_lane.g, dut.lfsr); end
        tests++; if (score2 !== 8'd0 || state2 !== 2'd0) begin fails++; $display("FAIL async_reset_dut2 got=%0d/%0d exp=0/0", score2, state2); end
        @(negedge Clk);
        Reset = 1'b1;
        model_reset();
        step();
        pixel(10, 10, 1'b0);
        Start = 1'b1;
        step();
        Start = 1'b0;
        mstate = 1;
        tick();
        tests++; if (State !== 2'd1 || dut.g_lanes[0].u_lane.x !== 11'd678 || dut.lfsr !== mlfsr) begin fails++; $display("FAIL post_reset_run got=%0d/%0d/%h exp=1/678/%h", State, dut.g_lanes[0].u_lane.x, dut.lfsr, mlfsr); end
    endtask

    initial begin
        test_reset();
        test_idle_frozen();
        test_run_score();
        test_wrap();
        test_collision();
        test_restart();
        test_saturation();
        test_reset_mid_run();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

`default_nettype wire
